// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS core: load-use/branch stalls, decode branch forwarding,
// and MDU busy-window sequencing (enabled only when HAZARD_MDU_EN is defined).
module hazard_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       BranchD,
  input  logic       HiLoReadD,
  input  logic       MdOpD,
  input  logic [4:0] WriteRegE,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       MultE,
  input  logic       DivE,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteM,
  input  logic       MemtoRegM,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MdStart,
  output logic       MdBusy,
  output logic       MdDone,
  output logic       md_state
);

  logic rs_nz, rt_nz;
  logic e_match, m_match;
  logic lwstall, branchstall, mdstall;

  always_comb begin
    rs_nz       = (RsD != 5'd0);
    rt_nz       = (RtD != 5'd0);
    ForwardAD   = rs_nz & (RsD == WriteRegM) & RegWriteM;
    ForwardBD   = rt_nz & (RtD == WriteRegM) & RegWriteM;
    // Nonzero-source gating keeps $0 from ever creating a dependency.
    e_match     = (rs_nz & (RsD == WriteRegE)) | (rt_nz & (RtD == WriteRegE));
    m_match     = (rs_nz & (RsD == WriteRegM)) | (rt_nz & (RtD == WriteRegM));
    lwstall     = MemtoRegE & RegWriteE & (WriteRegE != 5'd0) & e_match;
    branchstall = BranchD & ((RegWriteE & e_match) | (MemtoRegM & m_match));
    StallF      = lwstall | branchstall | mdstall;
    StallD      = StallF;
    FlushE      = StallF;
  end

`ifdef HAZARD_MDU_EN
  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  // The start cycle is the first busy cycle, so BUSY lasts LAT-1 cycles after it.
  always_comb begin
    MdStart  = ~rst & (state == IDLE) & (MultE | DivE);
    MdDone   = ~rst & (state == BUSY) & (cnt == CW'(1));
    MdBusy   = (state == BUSY) | MdStart;
    mdstall  = MdBusy & (HiLoReadD | MdOpD);
    md_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MultE | DivE) begin
            state <= BUSY;
            cnt   <= DivE ? DIV_LOAD : MUL_LOAD;
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= IDLE;
        end
      endcase
    end
  end
`else
  logic unused_md;

  always_comb begin
    MdStart   = 1'b0;
    MdDone    = 1'b0;
    MdBusy    = 1'b0;
    mdstall   = 1'b0;
    md_state  = 1'b0;
    unused_md = ^{clk, rst, MultE, DivE, HiLoReadD, MdOpD};
  end
`endif

endmodule
